// File: rtl/seven_seg_scan_decoder.sv
// Purpose: decodes a multiplexed active-low 4-digit 7-segment scan back into the 16-bit value shown (optional DP capture: SEG_DP_CAPTURE_EN).
// Latency: 2-cycle input sync + SETTLE_CYCLES stable samples per digit; value_valid 1 cycle after the final digit capture.
// Backpressure: none; passive monitor, value_valid is a single-cycle pulse with no ready.
module seven_seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an_n,
    input  logic [6:0]  seg_n,
    input  logic        dp_n,
    output logic [15:0] value,
    output logic        value_valid,
    output logic [3:0]  dp_out,
    output logic        bad_glyph,
    output logic        stalled
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // Sample word is {an_n, seg_n, dp}; with DP capture off the DP slot is a
    // constant 1 so dp_n never disturbs the stability compare.
`ifdef SEG_DP_CAPTURE_EN
    localparam int SW = 12;
    logic [SW-1:0] raw;
    assign raw = {an_n, seg_n, dp_n};
`else
    localparam int SW = 11;
    logic [SW-1:0] raw;
    logic          unused_dp;
    assign raw       = {an_n, seg_n};
    assign unused_dp = dp_n;
`endif

    logic [SW-1:0] sync1, sync2;
    logic [11:0]   samp;
    logic [11:0]   ref_s;
    logic [11:0]   next_ref;
    state_t        state, next_state;
    logic [SCW-1:0] stable_cnt, next_cnt;
    logic          capture;
    logic          reeval;
    logic          selectable;
    logic [4:0]    dec;
    logic [3:0]    cap_dig;
    logic          cap_ok, cap_bad;
    logic [3:0][3:0] nib;
    logic [3:0]    seen_mask;
    logic          frame;
    logic [TCW-1:0] idle_cnt;

    // Two-flop synchronizer; idles as "all lines dark"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    assign samp = sync2;
`else
    assign samp = {sync2, 1'b1};
`endif

    // A sample can only belong to a digit when exactly one anode is driven
    always_comb begin
        selectable = 1'b0;
        case (samp[11:8])
            4'b1110, 4'b1101, 4'b1011, 4'b0111: selectable = 1'b1;
            default:                            selectable = 1'b0;
        endcase
    end

    // Hex glyph lookup on lit segments (g..a); bit 4 flags a match
    function automatic logic [4:0] decode(input logic [6:0] lit);
        case (lit)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    // Settle FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stable_cnt <= '0;
            ref_s      <= '1;
        end else begin
            state      <= next_state;
            stable_cnt <= next_cnt;
            ref_s      <= next_ref;
        end
    end

    // Next state: any change of sample restarts as if from IDLE in the same cycle
    always_comb begin
        next_state = state;
        next_cnt   = stable_cnt;
        next_ref   = ref_s;
        capture    = 1'b0;
        reeval     = 1'b0;
        case (state)
            SETTLE: begin
                if (samp != ref_s) begin
                    reeval = 1'b1;
                end else if (stable_cnt == SCW'(SETTLE_CYCLES - 1)) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end else begin
                    next_cnt = stable_cnt + SCW'(1);
                end
            end
            HOLD: begin
                if (samp != ref_s) begin
                    reeval = 1'b1;
                end
            end
            default: reeval = 1'b1;
        endcase
        if (reeval) begin
            if (selectable) begin
                next_state = SETTLE;
                next_cnt   = SCW'(1);
                next_ref   = samp;
            end else begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        end
    end

    assign dec     = decode(~ref_s[7:1]);
    assign cap_dig = ~ref_s[11:8];
    assign cap_ok  = capture & dec[4];
    assign cap_bad = capture & ~dec[4];
    assign frame   = (seen_mask == 4'hF);

    // Digit capture, frame assembly and sticky glyph error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib         <= '0;
            seen_mask   <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            bad_glyph   <= 1'b0;
        end else begin
            value_valid <= frame;
            if (frame) begin
                value <= nib;
            end
            seen_mask <= (frame ? 4'h0 : seen_mask) | (cap_ok ? cap_dig : 4'h0);
            for (int i = 0; i < 4; i++) begin
                if (cap_ok && cap_dig[i]) begin
                    nib[i] <= dec[3:0];
                end
            end
            if (cap_bad) begin
                bad_glyph <= 1'b1;
            end
        end
    end

    // Saturating cycles-since-capture counter drives stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (cap_ok) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TCW'(TIMEOUT_CYCLES)) begin
            idle_cnt <= idle_cnt + TCW'(1);
        end
    end

    assign stalled = (idle_cnt == TCW'(TIMEOUT_CYCLES));

`ifdef SEG_DP_CAPTURE_EN
    logic [3:0] dp_pend;

    // DP state rides with each capture and is published with the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_pend <= '0;
            dp_out  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cap_ok && cap_dig[i]) begin
                    dp_pend[i] <= ~ref_s[0];
                end
            end
            if (frame) begin
                dp_out <= dp_pend;
            end
        end
    end
`else
    assign dp_out = 4'h0;
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
module tb_seven_seg_scan_decoder;

    localparam int SETTLE = 16;
    localparam int TMO    = 300;
    localparam int DWELL  = 40;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an_n  = 4'hF;
    logic [6:0]  seg_n = 7'h7F;
    logic        dp_n  = 1'b1;
    logic [15:0] value;
    logic        value_valid;
    logic [3:0]  dp_out;
    logic        bad_glyph;
    logic        stalled;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          vv_cnt   = 0;
    logic [15:0] last_val = 16'h0;

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .value      (value),
        .value_valid(value_valid),
        .dp_out     (dp_out),
        .bad_glyph  (bad_glyph),
        .stalled    (stalled)
    );

    always #5 clk = ~clk;

    // Frame monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && value_valid) begin
            vv_cnt   = vv_cnt + 1;
            last_val = value;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int i, input logic [6:0] lit, input logic dp, input int n);
        logic [3:0] one;
        one   = 4'b0001;
        an_n  = ~(one << i);
        seg_n = ~lit;
        dp_n  = ~dp;
        cyc(n);
    endtask

    task automatic scan(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] blank);
        for (int i = 0; i < 4; i++) begin
            show(i, blank[i] ? 7'h00 : glyph(v[4*i +: 4]), dpm[i], DWELL);
        end
    endtask

    initial begin
        int base;
        int n;
        logic got;

        // Reset state
        cyc(3);
        chk("rst_value", value, 16'h0);
        chk("rst_value_valid", value_valid, 0);
        chk("rst_dp_out", dp_out, 0);
        chk("rst_bad_glyph", bad_glyph, 0);
        chk("rst_stalled", stalled, 0);
        rst_n = 1'b1;
        cyc(2);

        // 1: two clean scans of 1A2F, then a latency probe on the last digit
        base = vv_cnt;
        scan(16'h1A2F, 4'h0, 4'h0);
        scan(16'h1A2F, 4'h0, 4'h0);
        chk("t1_frames", vv_cnt - base, 2);
        chk("t1_last_val", last_val, 16'h1A2F);
        chk("t1_bad_glyph", bad_glyph, 0);
        show(0, glyph(4'hF), 1'b0, DWELL);
        show(1, glyph(4'h2), 1'b0, DWELL);
        show(2, glyph(4'hA), 1'b0, DWELL);
        show(3, glyph(4'h1), 1'b0, 0);
        // 2 sync flops + 16 stable samples + 1 frame cycle = 19 edges
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            cyc(1);
            n++;
            if (value_valid) got = 1'b1;
        end
        chk("t1_latency", n, 19);
        chk("t1_value", value, 16'h1A2F);
        cyc(1);
        chk("t1_pulse_width", value_valid, 0);
        cyc(DWELL - 20);

        // 2: a short glitch to a valid glyph on digit 1 must not be captured
        base = vv_cnt;
        show(0, glyph(4'hF), 1'b0, DWELL);
        show(1, glyph(4'h2), 1'b0, 20);
        show(1, glyph(4'h8), 1'b0, 3);
        show(1, glyph(4'h2), 1'b0, 10);
        show(2, glyph(4'hA), 1'b0, DWELL);
        show(3, glyph(4'h1), 1'b0, DWELL);
        chk("t2_frames", vv_cnt - base, 1);
        chk("t2_value", last_val, 16'h1A2F);
        chk("t2_bad_glyph", bad_glyph, 0);

        // 3: blank digit 2 -> error, no frame; next scan completes using the
        //    digit 3 nibble (1) left from the broken scan
        base = vv_cnt;
        scan(16'h1A2F, 4'h0, 4'b0100);
        chk("t3_bad_glyph", bad_glyph, 1);
        chk("t3_no_frame", vv_cnt - base, 0);
        base = vv_cnt;
        scan(16'h1234, 4'h0, 4'h0);
        chk("t3_frames", vv_cnt - base, 1);
        chk("t3_value", last_val, 16'h1234);
        rst_n = 1'b0;
        an_n  = 4'hF;
        cyc(2);
        chk("t3_bad_cleared", bad_glyph, 0);
        rst_n = 1'b1;
        cyc(2);

        // 4: two anodes active must not capture anything
        base  = vv_cnt;
        an_n  = 4'b0011;
        seg_n = ~glyph(4'h5);
        cyc(100);
        show(0, glyph(4'hE), 1'b0, DWELL);
        show(1, glyph(4'h3), 1'b0, DWELL);
        chk("t4_no_early_frame", vv_cnt - base, 0);
        show(2, glyph(4'hC), 1'b0, DWELL);
        show(3, glyph(4'h5), 1'b0, DWELL);
        chk("t4_frames", vv_cnt - base, 1);
        chk("t4_value", last_val, 16'h5C3E);

        // 5: dark display -> stalled; clears on the first capture edge
        chk("t5_not_stalled", stalled, 0);
        an_n  = 4'hF;
        seg_n = 7'h7F;
        cyc(TMO + 1);
        chk("t5_stalled", stalled, 1);
        base = vv_cnt;
        show(0, glyph(4'hE), 1'b0, 17);
        chk("t5_stalled_pre_capture", stalled, 1);
        cyc(1);
        chk("t5_stall_cleared", stalled, 0);
        cyc(DWELL - 18);
        show(1, glyph(4'hD), 1'b0, DWELL);
        show(2, glyph(4'h0), 1'b0, DWELL);
        show(3, glyph(4'hC), 1'b0, DWELL);
        chk("t5_frames", vv_cnt - base, 1);
        chk("t5_value", last_val, 16'hC0DE);

        // 6: reset mid-frame discards partial digits
        show(0, glyph(4'h4), 1'b0, DWELL);
        show(1, glyph(4'h3), 1'b0, DWELL);
        rst_n = 1'b0;
        cyc(2);
        chk("t6_rst_value", value, 16'h0);
        chk("t6_rst_value_valid", value_valid, 0);
        rst_n = 1'b1;
        cyc(2);
        base = vv_cnt;
        scan(16'h0F0F, 4'b0001, 4'h0);
        chk("t6_frames", vv_cnt - base, 1);
        chk("t6_value", last_val, 16'h0F0F);
`ifdef SEG_DP_CAPTURE_EN
        chk("t6_dp_out", dp_out, 4'b0001);
`else
        chk("t6_dp_out", dp_out, 4'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
